// File: rtl/mux_scan_sampler_pkg.sv
// Shared definitions for the mux scan sampler: default sizes, FSM state codes
// and a helper that sizes the settle counter.
package mux_scan_sampler_pkg;

    localparam int NUM_INPUTS_DEF    = 7;
    localparam int SEL_WIDTH_DEF     = 3;
    localparam int SETTLE_CYCLES_DEF = 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    // The counter must hold SETTLE_CYCLES; a zero settle time still needs one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mux_scan_sampler_if.sv
// Scan-control and result bundle between board logic and the mux scan sampler.
// Optional Parity signal exists only when MUX_SCAN_PARITY_EN is defined.
interface mux_scan_sampler_if #(
    parameter int NUM_INPUTS = 7,
    parameter int SEL_WIDTH  = 3
);
    // start is a request sampled on any rising edge and accepted only while idle
    // (never queued); busy marks an active scan, and done pulses for exactly one
    // cycle when data/ones_count hold a completed scan (they stay valid until
    // the next accepted start).
    logic                  start;
    logic                  enable;
    logic                  mux_out;
    logic [SEL_WIDTH-1:0]  mux_select;
    logic [NUM_INPUTS-1:0] data;
    logic [SEL_WIDTH-1:0]  ones_count;
    logic                  busy;
    logic                  done;
    logic [1:0]            dbg_state;
`ifdef MUX_SCAN_PARITY_EN
    logic                  parity;
`endif

    modport master (
        output start, enable, mux_out,
        input  mux_select, data, ones_count, busy, done, dbg_state
`ifdef MUX_SCAN_PARITY_EN
        , input parity
`endif
    );

    modport slave (
        input  start, enable, mux_out,
        output mux_select, data, ones_count, busy, done, dbg_state
`ifdef MUX_SCAN_PARITY_EN
        , output parity
`endif
    );

endinterface

// File: rtl/mux_scan_sampler_settle_counter.sv
// Loadable down-counter that times the mux settle interval; expire flags the
// enabled edge on which the count reaches its last step.
module settle_counter #(
    parameter int W = 1
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    output logic         expire
);

    logic [W-1:0] count;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign expire = enable && (count == W'(1));

endmodule

// File: rtl/mux_scan_sampler.sv
// Steps a 7-to-1 mux through its selects, samples its output after a settle
// time and presents the reconstructed word. Option: MUX_SCAN_PARITY_EN adds parity.
module mux_scan_sampler
    import mux_scan_sampler_pkg::*;
#(
    parameter int NUM_INPUTS    = NUM_INPUTS_DEF,
    parameter int SEL_WIDTH     = SEL_WIDTH_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input logic               Clock,
    input logic               Resetn,
    mux_scan_sampler_if.slave bus
);

    localparam int                   CNT_W    = cnt_width(SETTLE_CYCLES);
    localparam logic [1:0]           S_FIRST  = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;
    localparam logic [SEL_WIDTH-1:0] SEL_LAST = SEL_WIDTH'(NUM_INPUTS - 1);

    logic [1:0]            state;
    logic [SEL_WIDTH-1:0]  sel;
    logic [NUM_INPUTS-1:0] data;
    logic [SEL_WIDTH-1:0]  ones;
    logic                  busy;
    logic                  done;

    logic                  accept;
    logic                  capture;
    logic                  advance;
    logic                  expire;
    logic [NUM_INPUTS-1:0] bit_mask;

    assign accept   = (state == S_IDLE) && bus.start;
    assign capture  = (state == S_SAMPLE) && bus.enable;
    assign advance  = capture && (sel != SEL_LAST);
    // data is cleared on accept, so OR-ing the sampled bit into place is enough.
    assign bit_mask = {{(NUM_INPUTS-1){1'b0}}, bus.mux_out} << sel;

    settle_counter #(.W(CNT_W)) u_settle (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .load       (accept || advance),
        .load_value (CNT_W'(SETTLE_CYCLES)),
        .enable     (bus.enable && (state == S_SETTLE)),
        .expire     (expire)
    );

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= S_IDLE;
            sel   <= '0;
            data  <= '0;
            ones  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        sel   <= '0;
                        data  <= '0;
                        ones  <= '0;
                        busy  <= 1'b1;
                        state <= S_FIRST;
                    end
                end
                S_SETTLE: begin
                    if (expire) state <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    if (bus.enable) begin
                        data <= data | bit_mask;
                        ones <= ones + SEL_WIDTH'(bus.mux_out);
                        if (sel == SEL_LAST) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            sel   <= sel + SEL_WIDTH'(1);
                            state <= S_FIRST;
                        end
                    end
                end
                S_DONE: begin
                    sel   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MUX_SCAN_PARITY_EN
    logic parity;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            parity <= 1'b0;
        end else if (accept) begin
            parity <= 1'b0;
        end else if (capture) begin
            parity <= parity ^ bus.mux_out;
        end
    end

    assign bus.parity = parity;
`endif

    assign bus.mux_select = sel;
    assign bus.data       = data;
    assign bus.ones_count = ones;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.dbg_state  = state;

endmodule
